// File: rtl/aux_winner_filter.sv
// aux_winner_filter
// Averages XADC AUX samples per channel, then picks the loudest channel with
// hysteresis and a consecutive-qualification filter before switching winner.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | accepting samples; waits for all four averages to be fresh
//   SCAN   | four cycles, running max over channels 0..3 (lowest wins ties)
//   DECIDE | one cycle, hysteresis test, stable counter, winner update
module aux_winner_filter #(
  parameter int DATA_W     = 12,
  parameter int AVG_LOG2   = 2,
  parameter int HYST       = 16,
  parameter int STABLE_CNT = 4
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic                  sample_valid,
  input  logic [1:0]            sample_ch,
  input  logic [DATA_W-1:0]     sample_data,
  output logic                  sample_ready,
  output logic [4*DATA_W-1:0]   avg_aux,
  output logic [1:0]            network_output,
  output logic                  decision_valid,
  output logic                  winner_changed
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int STB_W = $clog2(STABLE_CNT + 1);

  localparam logic [CNT_W-1:0]  LAST_CNT    = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [DATA_W:0]   HYST_EXT    = (DATA_W + 1)'(HYST);
  localparam logic [STB_W-1:0]  STABLE_LAST = STB_W'(STABLE_CNT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DECIDE = 2'd2
  } state_t;

  state_t            state;
  logic [ACC_W-1:0]  acc   [4];
  logic [CNT_W-1:0]  cnt   [4];
  logic [DATA_W-1:0] avg   [4];
  logic [3:0]        fresh;
  logic [1:0]        scan_idx;
  logic [1:0]        cand;
  logic [DATA_W-1:0] max_val;
  logic [STB_W-1:0]  stable;

  logic              accept;
  logic              last_sample;
  logic [ACC_W-1:0]  sum_in;
  logic [DATA_W:0]   thresh;
  logic              qualify;
  logic [STB_W-1:0]  stable_inc;

  // Samples are only taken while idle, so averages are frozen during SCAN
  // and DECIDE and the scan always sees the values present at SCAN start.
  assign sample_ready = (state == IDLE);
  assign accept       = sample_valid && sample_ready;
  assign sum_in       = acc[sample_ch] + ACC_W'(sample_data);
  assign last_sample  = (cnt[sample_ch] == LAST_CNT);

  // Threshold is one bit wider than a sample so a high winner cannot wrap.
  assign thresh     = {1'b0, avg[network_output]} + HYST_EXT;
  assign qualify    = (cand != network_output) && ({1'b0, avg[cand]} > thresh);
  assign stable_inc = stable + 1'b1;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_avg_out
      assign avg_aux[g*DATA_W +: DATA_W] = avg[g];
    end
  endgenerate

  // Per-channel accumulate; the completing sample is folded into the average
  // directly so nothing is dropped when a block of samples finishes.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < 4; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
        avg[i] <= '0;
      end
      fresh <= '0;
    end else begin
      if (state == DECIDE) begin
        fresh <= '0;
      end
      if (accept) begin
        if (last_sample) begin
          acc[sample_ch]   <= '0;
          cnt[sample_ch]   <= '0;
          avg[sample_ch]   <= DATA_W'(sum_in >> AVG_LOG2);
          fresh[sample_ch] <= 1'b1;
        end else begin
          acc[sample_ch] <= sum_in;
          cnt[sample_ch] <= cnt[sample_ch] + 1'b1;
        end
      end
    end
  end

  // Sequencer: scan for the max, then apply hysteresis and stability filter.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state          <= IDLE;
      scan_idx       <= '0;
      cand           <= '0;
      max_val        <= '0;
      stable         <= '0;
      network_output <= '0;
      decision_valid <= 1'b0;
      winner_changed <= 1'b0;
    end else begin
      decision_valid <= 1'b0;
      winner_changed <= 1'b0;
      case (state)
        IDLE: begin
          if (fresh == 4'hF) begin
            state    <= SCAN;
            scan_idx <= '0;
          end
        end
        SCAN: begin
          // Strict greater-than keeps the lowest index on equal averages.
          if ((scan_idx == 2'd0) || (avg[scan_idx] > max_val)) begin
            cand    <= scan_idx;
            max_val <= avg[scan_idx];
          end
          scan_idx <= scan_idx + 2'd1;
          if (scan_idx == 2'd3) begin
            state <= DECIDE;
          end
        end
        DECIDE: begin
          decision_valid <= 1'b1;
          state          <= IDLE;
          // Counter tracks qualification only; a new challenger identity
          // does not restart it.
          if (qualify) begin
            if (stable_inc == STABLE_LAST) begin
              network_output <= cand;
              stable         <= '0;
              winner_changed <= 1'b1;
            end else begin
              stable <= stable_inc;
            end
          end else begin
            stable <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aux_winner_filter.sv
// Directed bench for aux_winner_filter with a decision scoreboard.
module tb_aux_winner_filter;

  localparam int DW     = 12;
  localparam int NAVG   = 4;
  localparam int HYST   = 16;
  localparam int STABLE = 4;

  logic            clk;
  logic            rst_n;
  logic            sample_valid;
  logic [1:0]      sample_ch;
  logic [DW-1:0]   sample_data;
  logic            sample_ready;
  logic [4*DW-1:0] avg_aux;
  logic [1:0]      network_output;
  logic            decision_valid;
  logic            winner_changed;

  aux_winner_filter #(
    .DATA_W(DW), .AVG_LOG2(2), .HYST(HYST), .STABLE_CNT(STABLE)
  ) dut (
    .S_AXI_ACLK     (clk),
    .S_AXI_ARESETN  (rst_n),
    .sample_valid   (sample_valid),
    .sample_ch      (sample_ch),
    .sample_data    (sample_data),
    .sample_ready   (sample_ready),
    .avg_aux        (avg_aux),
    .network_output (network_output),
    .decision_valid (decision_valid),
    .winner_changed (winner_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int win;
    int chg;
  } dec_t;

  dec_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   dv_count = 0;

  int   m_acc[4];
  int   m_cnt[4];
  int   m_avg[4];
  int   m_fresh[4];
  int   m_win;
  int   m_stable;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_acc[i] = 0; m_cnt[i] = 0; m_avg[i] = 0; m_fresh[i] = 0;
    end
    m_win = 0;
    m_stable = 0;
    q.delete();
  endtask

  task automatic model_decide();
    int   cand;
    dec_t d;
    cand = 0;
    for (int i = 1; i < 4; i++) if (m_avg[i] > m_avg[cand]) cand = i;
    d.chg = 0;
    if (cand != m_win && m_avg[cand] > m_avg[m_win] + HYST) begin
      m_stable++;
      if (m_stable == STABLE) begin
        m_win = cand;
        m_stable = 0;
        d.chg = 1;
      end
    end else begin
      m_stable = 0;
    end
    d.win = m_win;
    q.push_back(d);
  endtask

  // Drive one sample and hold it until accepted; report cycles stalled.
  task automatic send(input int ch, input int val, output int waits);
    int w;
    bit ok;
    w = 0;
    ok = 0;
    sample_valid = 1'b1;
    sample_ch    = ch[1:0];
    sample_data  = val[DW-1:0];
    while (!ok && w <= 40) begin
      @(negedge clk);
      if (sample_ready) ok = 1; else w++;
    end
    waits = w;
    if (!ok) begin
      chk("send_timeout", 0, 1);
      sample_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    m_acc[ch] += val;
    m_cnt[ch]++;
    if (m_cnt[ch] == NAVG) begin
      m_avg[ch] = m_acc[ch] / NAVG;
      m_acc[ch] = 0;
      m_cnt[ch] = 0;
      m_fresh[ch] = 1;
      if (m_fresh[0] && m_fresh[1] && m_fresh[2] && m_fresh[3]) begin
        model_decide();
        for (int i = 0; i < 4; i++) m_fresh[i] = 0;
      end
    end
  endtask

  task automatic idle();
    sample_valid = 1'b0;
  endtask

  task automatic wait_decision(input int lat);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < 30) begin
      @(negedge clk);
      n++;
      if (decision_valid) seen = 1;
    end
    if (!seen) chk("decision_timeout", 0, 1);
    else if (lat > 0) chk("decision_latency", n, lat);
    @(posedge clk);
    #1;
  endtask

  task automatic do_round(input int v0, input int v1, input int v2, input int v3);
    int w;
    int v[4];
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < NAVG; k++) send(c, v[c], w);
    idle();
    wait_decision(7);
  endtask

  // Continuous-valid round; values vary per sample to expose lost/dup samples.
  task automatic bp_round(input int base, output int max_w);
    int w;
    max_w = 0;
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < NAVG; k++) begin
        send(c, base + c * 37 + k * 3, w);
        if (w > max_w) max_w = w;
      end
  endtask

  task automatic check_avgs(input string tag);
    for (int c = 0; c < 4; c++) chk(tag, avg_aux[c*DW +: DW], m_avg[c]);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every decision pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && decision_valid === 1'b1) begin
      dv_count++;
      if (q.size() == 0) begin
        chk("unexpected_decision", 1, 0);
      end else begin
        dec_t e;
        e = q.pop_front();
        chk("dec_winner", network_output, e.win);
        chk("dec_changed", winner_changed, e.chg);
      end
    end
  end

  initial begin
    int w;
    int dv0;
    rst_n = 1'b0;
    sample_valid = 1'b0;
    sample_ch = '0;
    sample_data = '0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_avg", avg_aux, 0);
    chk("rst_winner", network_output, 0);
    chk("rst_dv", decision_valid, 0);
    chk("rst_wc", winner_changed, 0);
    chk("rst_ready", sample_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Averaging on ch2 alone: no decision
    dv0 = dv_count;
    send(2, 100, w); send(2, 102, w); send(2, 104, w); send(2, 106, w);
    idle();
    repeat (10) @(posedge clk);
    #1;
    chk("avg_ch2", avg_aux[2*DW +: DW], 103);
    chk("avg_ch2_nodec", dv_count, dv0);

    // Tie: lowest index is candidate, never switches
    apply_reset();
    repeat (3) do_round(300, 300, 300, 300);
    chk("tie_winner", network_output, 0);

    // Decision latency and switch on 4th qualifying decision
    apply_reset();
    repeat (4) do_round(200, 800, 200, 200);
    chk("lat_winner", network_output, 1);
    check_avgs("lat_avg");

    // Hysteresis: 515 is within margin, 517 is not
    apply_reset();
    repeat (10) do_round(500, 100, 100, 515);
    chk("hyst_hold", network_output, 0);
    repeat (4) do_round(500, 100, 100, 517);
    chk("hyst_switch", network_output, 3);

    // Challenger changes identity: counter keeps counting qualifications
    repeat (2) do_round(100, 600, 100, 100);
    repeat (2) do_round(100, 600, 700, 100);
    chk("ident_switch", network_output, 2);

    // Partial coverage: no decision while a channel is missing
    dv0 = dv_count;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        for (int k = 0; k < NAVG; k++) send(c, 50 + r * 400 + c * 10, w);
    idle();
    repeat (10) @(posedge clk);
    #1;
    chk("partial_nodec", dv_count, dv0);
    for (int k = 0; k < NAVG; k++) send(3, 40, w);
    idle();
    wait_decision(7);
    chk("partial_one_dec", dv_count, dv0 + 1);
    check_avgs("partial_avg");

    // Backpressure: valid held through SCAN/DECIDE
    bp_round(120, w);
    chk("bp_first_stall", w, 0);
    bp_round(260, w);
    chk("bp_stall_len", w, 5);
    bp_round(410, w);
    chk("bp_stall_len2", w, 5);
    idle();
    check_avgs("bp_avg");
    wait_decision(7);

    // Reset during the 2nd SCAN cycle
    do_round(900, 100, 100, 100);
    do_round(900, 100, 100, 100);
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < NAVG; k++) send(c, 900 - c * 100, w);
    idle();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_avg", avg_aux, 0);
    chk("mid_rst_winner", network_output, 0);
    chk("mid_rst_dv", decision_valid, 0);
    chk("mid_rst_wc", winner_changed, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", sample_ready, 1);
    dv0 = dv_count;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_nodec", dv_count, dv0);

    // Recovery after reset
    do_round(300, 300, 310, 300);
    chk("recover_winner", network_output, 0);
    chk("queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aux_winner_filter.md
AUX_WINNER_FILTER -- requirements
Module: aux_winner_filter

Interface
REQ-001 SHALL have parameter DATA_W, default 12, meaning the width of one XADC AUX sample.
REQ-002 SHALL have parameter AVG_LOG2, default 2, meaning log2 of the number of samples averaged per channel.
REQ-003 SHALL have parameter HYST, default 16, meaning the margin a challenger average must exceed the current winner's average by.
REQ-004 SHALL have parameter STABLE_CNT, default 4, meaning the number of consecutive qualifying decisions needed before the winner switches.
REQ-005 SHALL have port S_AXI_ACLK, input, width 1, the single clock for the block.
REQ-006 SHALL have port S_AXI_ARESETN, input, width 1: one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port sample_valid, input, width 1, meaning sample_ch/sample_data are valid.
REQ-008 SHALL have port sample_ch, input, width 2, meaning the AUX channel index 0-3.
REQ-009 SHALL have port sample_data, input, width DATA_W, meaning the measured AUX value.
REQ-010 SHALL have port sample_ready, output, width 1, meaning the block accepts a sample this cycle.
REQ-011 SHALL have port avg_aux, output, width 4*DATA_W, holding the channel n average in bits [n*DATA_W +: DATA_W].
REQ-012 SHALL have port network_output, output, width 2, meaning the filtered winning channel index.
REQ-013 SHALL have port decision_valid, output, width 1, a one-cycle pulse at each completed decision.
REQ-014 SHALL have port winner_changed, output, width 1, a one-cycle pulse coincident with decision_valid when network_output changes.

Function
REQ-015 SHALL accept a sample only on a cycle where sample_valid and sample_ready are both high.
REQ-016 SHALL hold sample_ready high in state IDLE and low in states SCAN and DECIDE.
REQ-017 SHALL add each accepted sample into a per-channel accumulator of width DATA_W+AVG_LOG2 that never wraps, and SHALL increment that channel's sample count.
REQ-018 SHALL, when the count reaches 2^AVG_LOG2, load avg_aux[ch] with accumulator>>AVG_LOG2 on the next edge, clear that accumulator and count, and set fresh[ch].
REQ-019 SHALL, in the cycle that completes a channel, load the completed sum directly so that no sample is lost.
REQ-020 SHALL use FSM states IDLE, SCAN and DECIDE: IDLE goes to SCAN the cycle after fresh becomes 4'b1111; SCAN lasts exactly 4 cycles, examining channel 0,1,2,3 in order; then DECIDE lasts 1 cycle; then IDLE.
REQ-021 SHALL in SCAN keep a running maximum using strict greater-than, so that on equal averages the lowest index wins.
REQ-022 SHALL in DECIDE compare avg[cand] against avg[winner]+HYST computed in DATA_W+1 bits (no overflow wrap).
REQ-023 SHALL in DECIDE increment the stable counter when cand differs from winner and exceeds the sum; otherwise it SHALL clear the counter to 0.
REQ-024 SHALL in DECIDE, when the incremented counter equals STABLE_CNT, set network_output to cand, clear the counter and pulse winner_changed.
REQ-025 SHALL in DECIDE pulse decision_valid and clear fresh to 0.
REQ-026 SHALL leave fresh bits set when a channel completes again before DECIDE; the newer average overwrites the older one, and the scan uses the values captured at SCAN start.
REQ-027 SHALL generate no decision while any fresh bit is 0, regardless of how many samples arrive on the other channels.
REQ-028 SHALL give a switch priority over a stable-counter clear when a challenger changes identity: the counter tracks qualification only, not the candidate index.

Reset
REQ-029 SHALL, on S_AXI_ARESETN low (asynchronously), clear accumulators, counts, fresh, avg_aux, the stable counter and network_output to 0, set decision_valid and winner_changed to 0, and enter IDLE.
REQ-030 SHALL, when reset is asserted mid-SCAN or mid-DECIDE, abort without a decision pulse and set sample_ready to 1 in the first cycle after release.

Verification
REQ-031 Averaging: send 4 samples on ch2 with values 100,102,104,106 -> avg_aux[2]=103, fresh[2]=1, no decision_valid.
REQ-032 Decision latency: complete all 4 channels, ch1 avg 800, others 200 -> SCAN starts the cycle after the last fresh bit and decision_valid pulses 5 cycles later; network_output stays 0 until the 4th such decision, then changes to 1 with winner_changed=1.
REQ-033 Hysteresis: winner 0 avg 500, ch3 avg 515 for 10 decisions -> network_output stays 0; ch3 avg 517 for 4 decisions -> switches to 3.
REQ-034 Tie: all channels 300 from reset -> the candidate is 0 and no switch ever occurs.
REQ-035 Backpressure: hold sample_valid high through SCAN and DECIDE -> sample_ready is low for 5 cycles, and no samples are lost or double-counted.
REQ-036 Reset mid-SCAN: assert S_AXI_ARESETN=0 during the 2nd SCAN cycle -> all outputs are 0, no decision_valid, and sample_ready=1 after release.
